alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer that shares the single combinational ALU between two requesters (e.g. the execute stage and the address-generation path). It accepts one operation at a time through a request/acknowledge handshake and picks fairly between simultaneous requests. It registers the winner's operands onto the ALU inputs, captures OUT/ZERO one cycle later, and returns them to the winner with a one-cycle acknowledge. It sits directly in front of the ALU instance; the ALU itself is unchanged.

## Interface
- DATA_WIDTH, `DATA_WIDTH (32): operand/result width.
- OPRN_WIDTH, `ALU_OPRN_WIDTH (6): ALU opcode width.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- REQ0 / REQ1  in  1  request from requester 0 / 1. Held high with operands stable until the matching ACK.
- OP1_0, OP2_0 / OP1_1, OP2_1  in  DATA_WIDTH  operands per requester.
- OPRN_0 / OPRN_1  in  OPRN_WIDTH  opcode per requester.
- ACK0 / ACK1  out  1  one-cycle completion pulse.
- RES0 / RES1  out  DATA_WIDTH  result. Valid while ACK is high; held until that requester's next ACK.
- ZERO0 / ZERO1  out  1  zero flag. Same timing as RES.
- ERR0 / ERR1  out  1  asserted with ACK when the opcode was rejected.
- ALU_OP1, ALU_OP2  out  DATA_WIDTH  registered operands to the ALU.
- ALU_OPRN  out  OPRN_WIDTH  registered opcode to the ALU.
- ALU_OUT  in  DATA_WIDTH  ALU result.
- ALU_ZERO  in  1  ALU zero flag.
- BUSY  out  1  high in EXEC and RESP.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If no REQ is high, stay in IDLE.
  - Otherwise choose a winner. If only one REQ is high, that requester wins. If both are high, the requester not granted last wins. Then update LAST := winner.
  - Valid opcode (0x01..0x09): register the winner's OP1/OP2/OPRN onto ALU_OP1/ALU_OP2/ALU_OPRN and go to EXEC.
  - Invalid opcode (0x00 or ≥0x0A): the ALU inputs are not updated. Set RES := 0, ZERO := 0, ERR := 1 for the winner and go to RESP.
- EXEC: on the clock edge ending this state, capture ALU_OUT into RESn and ALU_ZERO into ZEROn for the winner, with ERRn := 0. Go to RESP.
- RESP:
  - ACKn is high for exactly this cycle; ERRn is high this cycle only if the opcode was rejected.
  - Always returns to IDLE.
  - REQn is not sampled in RESP. A requester that samples ACK high drops REQ for the following IDLE cycle. A REQ still high in that IDLE cycle is a new request.
- The loser of a simultaneous request keeps REQ high and is granted in the next IDLE cycle. Starvation is impossible.
- ALU_OP1/ALU_OP2/ALU_OPRN hold their last values in IDLE and RESP.
- The requester that was not granted sees no change on its RES/ZERO/ACK/ERR.
- Width rules:
  - Operands and result are DATA_WIDTH and passed through unmodified; no sign or zero extension.
  - ALU_ZERO is taken verbatim. The arbiter does not recompute it.

## Timing
- Reset values (RST low, asynchronous): state IDLE, LAST=1 (requester 0 wins the first tie), all ACK/ERR=0, BUSY=0, RES0/RES1=0, ZERO0/ZERO1=0, ALU_OP1/ALU_OP2=0, ALU_OPRN=0.
- Reset mid-operation (EXEC or RESP): the operation is aborted and no ACK is issued. The requester must re-present the request after reset release.
- Valid op latency, with REQ sampled at edge T in IDLE:
  - EXEC during cycle T+1.
  - ACK and RES valid during cycle T+2.
- Invalid op: ACK and ERR during cycle T+1.
- Throughput: one valid op per 3 cycles; one rejected op per 2 cycles.
- REQ changing before ACK is a protocol violation; the arbiter uses the values registered in IDLE.

## Structure
- Add to prj_definition.v:
  - state encodings `ARB_ST_IDLE=2'b00, `ARB_ST_EXEC=2'b01, `ARB_ST_RESP=2'b10;
  - `ALU_OPRN_MIN=6'h01 and `ALU_OPRN_MAX=6'h09.
- Reuse `DATA_WIDTH and `ALU_OPRN_WIDTH.
- One sub-module is natural: alu_rr_picker (combinational). Inputs REQ0, REQ1, LAST; outputs GNT_VALID, GNT_ID.
- The testbench instantiates alu_arbiter and ALU together.

## Test plan
- After reset, REQ0 only with OP1=5, OP2=3, OPRN=0x01. Required: ACK0 exactly 2 cycles after sampling, RES0=8, ZERO0=0, ERR0=0, ACK1 never high.
- REQ0 and REQ1 raised in the same cycle, both with valid opcodes:
  - requester 0: 0x02, 7−7;
  - requester 1: 0x06, 0xF0&0x0F.
  - Required: ACK0 first with RES0=0, ZERO0=1; then ACK1 with RES1=0, ZERO1=1 (AND of 0xF0 and 0x0F yields 0).
- Both REQ held continuously for 6 operations. Required: grants alternate 0,1,0,1,0,1 and each ACK is 3 cycles apart.
- REQ1 with OPRN=0x0A. Required: ACK1 and ERR1 one cycle after sampling, RES1=0, ALU_OPRN unchanged, BUSY high for 1 cycle.
- REQ0 with 0x05, 1<<4 (OP1=1, OP2=4); RST pulsed low during EXEC. Required: immediate return to reset values, no ACK0. After release, re-request gives RES0=0x10.
- REQ0 with 0x09, 2<3. Required: RES0=1. RES0 then holds 1 while requester 1 completes 0x03, 6×7 with RES1=42.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared widths, opcode range, FSM encoding and opcode check for the ALU arbiter
package alu_arbiter_pkg;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_OPRN_WIDTH = 6;
  localparam logic [31:0] OPRN_MIN = 32'h01;
  localparam logic [31:0] OPRN_MAX = 32'h09;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;
  function automatic logic oprn_valid(input logic [31:0] oprn);
    return (oprn >= OPRN_MIN) && (oprn <= OPRN_MAX);
  endfunction
endpackage

// File: rtl/alu_rr_picker.sv
// alu_rr_picker: two-way round-robin choice
//   req0/req1 : pending requests
//   last      : id granted most recently
//   gnt_valid : at least one request pending
//   gnt_id    : winning requester (the one not granted last on a tie)
module alu_rr_picker (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = (req0 & req1) ? ~last : req1;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with a req/ack handshake
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req0/1, op1_0/1, op2_0/1,
//   oprn_0/1                    : per-requester request, operands and opcode
//   ack0/1, res0/1, zero0/1,
//   err0/1                      : per-requester completion pulse, held result, zero flag, reject flag
//   alu_op1, alu_op2, alu_oprn  : registered ALU inputs
//   alu_out, alu_zero           : ALU result and zero flag
//   busy                        : high while an operation is in EXEC or RESP
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int OPRN_WIDTH = ARB_OPRN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] op1_0,
  input  logic [DATA_WIDTH-1:0] op2_0,
  input  logic [OPRN_WIDTH-1:0] oprn_0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] op1_1,
  input  logic [DATA_WIDTH-1:0] op2_1,
  input  logic [OPRN_WIDTH-1:0] oprn_1,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] res0,
  output logic                  zero0,
  output logic                  err0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] res1,
  output logic                  zero1,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [OPRN_WIDTH-1:0] alu_oprn,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_zero,
  output logic                  busy
);
  arb_state_e            state, state_next;
  logic                  last, win, err_r;
  logic                  gnt_valid, gnt_id, sel_ok;
  logic [OPRN_WIDTH-1:0] sel_oprn;

  alu_rr_picker u_picker (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    sel_oprn = gnt_id ? oprn_1 : oprn_0;
    sel_ok   = oprn_valid(32'(sel_oprn));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: state_next = !gnt_valid ? ST_IDLE : (sel_ok ? ST_EXEC : ST_RESP);
      ST_EXEC: state_next = ST_RESP;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = state != ST_IDLE;
    ack0 = (state == ST_RESP) && !win;
    ack1 = (state == ST_RESP) && win;
    err0 = ack0 && err_r;
    err1 = ack1 && err_r;
  end

  // Grant bookkeeping and ALU operand registers; rejected opcodes leave the ALU inputs untouched.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last     <= 1'b1;
      win      <= 1'b0;
      err_r    <= 1'b0;
      alu_op1  <= '0;
      alu_op2  <= '0;
      alu_oprn <= '0;
    end else if (state == ST_IDLE && gnt_valid) begin
      last  <= gnt_id;
      win   <= gnt_id;
      err_r <= !sel_ok;
      if (sel_ok) begin
        alu_op1  <= gnt_id ? op1_1 : op1_0;
        alu_op2  <= gnt_id ? op2_1 : op2_0;
        alu_oprn <= sel_oprn;
      end
    end

  // Per-requester result holding: written on reject (cleared) or at the end of EXEC (captured).
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res0  <= '0;
      zero0 <= 1'b0;
      res1  <= '0;
      zero1 <= 1'b0;
    end else if (state == ST_IDLE && gnt_valid && !sel_ok) begin
      if (gnt_id) begin
        res1  <= '0;
        zero1 <= 1'b0;
      end else begin
        res0  <= '0;
        zero0 <= 1'b0;
      end
    end else if (state == ST_EXEC) begin
      if (win) begin
        res1  <= alu_out;
        zero1 <= alu_zero;
      end else begin
        res0  <= alu_out;
        zero0 <= alu_zero;
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter driving a behavioural ALU
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] op1_0 = '0, op2_0 = '0, op1_1 = '0, op2_1 = '0;
  logic [5:0]  oprn_0 = '0, oprn_1 = '0;
  logic        ack0, ack1, zero0, zero1, err0, err1, busy;
  logic [31:0] res0, res1, alu_op1, alu_op2, alu_out;
  logic [5:0]  alu_oprn;
  logic        alu_zero;

  typedef struct {
    logic [5:0]  oprn;
    logic [31:0] a, b, res;
    logic        zero, err;
    int          lat;
  } op_t;

  op_t p0[$], p1[$], e0[$], e1[$];
  int  gid[$], gcyc[$];
  int  tests = 0, fails = 0, cyc = 0, raise0 = 0, raise1 = 0, busy_cnt = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_oprn)
      6'h01:   alu_out = alu_op1 + alu_op2;
      6'h02:   alu_out = alu_op1 - alu_op2;
      6'h03:   alu_out = alu_op1 * alu_op2;
      6'h04:   alu_out = alu_op1 >> alu_op2;
      6'h05:   alu_out = alu_op1 << alu_op2;
      6'h06:   alu_out = alu_op1 & alu_op2;
      6'h07:   alu_out = alu_op1 | alu_op2;
      6'h08:   alu_out = ~(alu_op1 | alu_op2);
      6'h09:   alu_out = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
      default: alu_out = '0;
    endcase
    alu_zero = alu_out == 32'b0;
  end

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op1_0(op1_0), .op2_0(op2_0), .oprn_0(oprn_0),
    .req1(req1), .op1_1(op1_1), .op2_1(op2_1), .oprn_1(oprn_1),
    .ack0(ack0), .res0(res0), .zero0(zero0), .err0(err0),
    .ack1(ack1), .res1(res1), .zero1(zero1), .err1(err1),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_oprn(alu_oprn),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  function automatic op_t mk(input logic [5:0] oprn, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] res, input logic zero, input logic err, input int lat);
    op_t o;
    o.oprn = oprn; o.a = a; o.b = b; o.res = res; o.zero = zero; o.err = err; o.lat = lat;
    return o;
  endfunction

  // Both requesters behave like real clients: raise with operands, hold until ACK,
  // drop through the following IDLE cycle, then present the next queued op.
  task automatic serve(input int n, input int budget);
    int done = 0, cool0 = 0, cool1 = 0, c = 0;
    op_t o;
    while (done < n && c < budget) begin
      @(negedge clk);
      c++; cyc++;
      if (busy) busy_cnt++;
      if (ack0) begin
        tests++; done++; gid.push_back(0); gcyc.push_back(cyc);
        if (e0.size() == 0) begin
          fails++; $display("FAIL ack0_unexpected: ack0=1 res0=%h, required no ack0", res0);
        end else begin
          o = e0.pop_front();
          if (res0 !== o.res || zero0 !== o.zero || err0 !== o.err || (o.lat != 0 && cyc - raise0 != o.lat)) begin
            fails++;
            $display("FAIL ack0_result: res=%h zero=%b err=%b lat=%0d, required res=%h zero=%b err=%b lat=%0d",
                     res0, zero0, err0, cyc - raise0, o.res, o.zero, o.err, o.lat);
          end
        end
        req0 = 1'b0; cool0 = 1;
      end else if (cool0 > 0) cool0--;
      else if (!req0 && p0.size() > 0) begin
        o = p0.pop_front();
        op1_0 = o.a; op2_0 = o.b; oprn_0 = o.oprn; req0 = 1'b1; raise0 = cyc; e0.push_back(o);
      end
      if (ack1) begin
        tests++; done++; gid.push_back(1); gcyc.push_back(cyc);
        if (e1.size() == 0) begin
          fails++; $display("FAIL ack1_unexpected: ack1=1 res1=%h, required no ack1", res1);
        end else begin
          o = e1.pop_front();
          if (res1 !== o.res || zero1 !== o.zero || err1 !== o.err || (o.lat != 0 && cyc - raise1 != o.lat)) begin
            fails++;
            $display("FAIL ack1_result: res=%h zero=%b err=%b lat=%0d, required res=%h zero=%b err=%b lat=%0d",
                     res1, zero1, err1, cyc - raise1, o.res, o.zero, o.err, o.lat);
          end
        end
        req1 = 1'b0; cool1 = 1;
      end else if (cool1 > 0) cool1--;
      else if (!req1 && p1.size() > 0) begin
        o = p1.pop_front();
        op1_1 = o.a; op2_1 = o.b; oprn_1 = o.oprn; req1 = 1'b1; raise1 = cyc; e1.push_back(o);
      end
    end
    if (done < n) begin
      tests++; fails++;
      $display("FAIL serve_timeout: %0d acks seen, required %0d", done, n);
    end
    @(negedge clk);
    cyc++;
    if (ack0 || ack1) begin
      tests++; fails++;
      $display("FAIL stray_ack: ack0=%b ack1=%b, required 0 0", ack0, ack1);
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc += 2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({ack0, ack1, err0, err1, busy, zero0, zero1} !== 7'b0 || res0 !== 0 || res1 !== 0 ||
        alu_op1 !== 0 || alu_op2 !== 0 || alu_oprn !== 0) begin
      fails++;
      $display("FAIL reset_values: ack=%b%b err=%b%b busy=%b res0=%h res1=%h alu=%h/%h/%h, required all zero",
               ack0, ack1, err0, err1, busy, res0, res1, alu_op1, alu_op2, alu_oprn);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    p0.push_back(mk(6'h01, 5, 3, 8, 1'b0, 1'b0, 2));
    serve(1, 20);
  endtask

  task automatic test_simultaneous();
    do_reset();
    gid.delete(); gcyc.delete();
    p0.push_back(mk(6'h02, 7, 7, 0, 1'b1, 1'b0, 0));
    p1.push_back(mk(6'h06, 32'hF0, 32'h0F, 0, 1'b1, 1'b0, 0));
    serve(2, 30);
    tests++;
    if (gid.size() != 2 || gid[0] != 0 || gid[1] != 1) begin
      fails++; $display("FAIL tie_order: %0d grants first=%0d, required 2 grants 0 then 1", gid.size(), gid.size() > 0 ? gid[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    gid.delete(); gcyc.delete();
    for (int i = 1; i <= 3; i++) begin
      p0.push_back(mk(6'h01, i, i, 2 * i, 1'b0, 1'b0, 0));
      p1.push_back(mk(6'h02, 9, i, 9 - i, 1'b0, 1'b0, 0));
    end
    serve(6, 60);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= gid.size() || gid[i] != i % 2 || (i > 0 && gcyc[i] - gcyc[i-1] != 3)) begin
        fails++;
        $display("FAIL alternate_%0d: id=%0d gap=%0d, required id=%0d gap=3", i,
                 i < gid.size() ? gid[i] : -1, (i > 0 && i < gid.size()) ? gcyc[i] - gcyc[i-1] : 3, i % 2);
      end
    end
  endtask

  task automatic test_invalid();
    logic [5:0] prev;
    prev = alu_oprn;
    busy_cnt = 0;
    p1.push_back(mk(6'h0A, 1, 2, 0, 1'b0, 1'b1, 1));
    serve(1, 10);
    tests++;
    if (alu_oprn !== prev || busy_cnt != 1) begin
      fails++; $display("FAIL invalid_side: alu_oprn=%h busy_cycles=%0d, required alu_oprn=%h busy_cycles=1", alu_oprn, busy_cnt, prev);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    op1_0 = 1; op2_0 = 4; oprn_0 = 6'h05; req0 = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || alu_oprn !== 6'h05) begin
      fails++; $display("FAIL exec_entry: busy=%b alu_oprn=%h, required busy=1 alu_oprn=05", busy, alu_oprn);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || ack0 !== 1'b0 || alu_op1 !== 0 || alu_op2 !== 0 || alu_oprn !== 0 || res0 !== 0) begin
      fails++;
      $display("FAIL async_reset: busy=%b ack0=%b alu=%h/%h/%h res0=%h, required all zero",
               busy, ack0, alu_op1, alu_op2, alu_oprn, res0);
    end
    req0 = 1'b0;
    @(negedge clk);
    tests++;
    if (ack0 !== 1'b0) begin
      fails++; $display("FAIL aborted_ack: ack0=%b, required 0", ack0);
    end
    rst_n = 1'b1;
    p0.push_back(mk(6'h05, 1, 4, 32'h10, 1'b0, 1'b0, 2));
    serve(1, 20);
  endtask

  task automatic test_hold();
    p0.push_back(mk(6'h09, 2, 3, 1, 1'b0, 1'b0, 2));
    serve(1, 20);
    p1.push_back(mk(6'h03, 6, 7, 42, 1'b0, 1'b0, 2));
    serve(1, 20);
    tests++;
    if (res0 !== 32'd1 || zero0 !== 1'b0 || res1 !== 32'd42) begin
      fails++; $display("FAIL result_hold: res0=%h zero0=%b res1=%h, required res0=1 zero0=0 res1=2a", res0, zero0, res1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_invalid();
    test_reset_mid_op();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
